// File: rtl/inst_package.sv
// Instruction field layout, decoded slot format and opcode helpers shared by
// the decode/issue stage and its scoreboard.
package inst_package;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RS1_MSB = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_MSB = 15;
  localparam int RS2_LSB = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [5:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_LD  = 6'd3,
    OP_ST  = 6'd4,
    OP_BEQ = 6'd5
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        we;
    logic        ld;
  } decoded_t;

  typedef enum logic [0:0] {
    S_FULL   = 1'b0,
    S_SECOND = 1'b1
  } issue_state_t;

  localparam decoded_t NOP = '{op: OP_NOP, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                               imm: 32'd0, we: 1'b0, ld: 1'b0};

  function automatic logic is_load(input op_t op);
    return (op == OP_LD);
  endfunction

  function automatic logic writes_rd(input op_t op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_LD: w = 1'b1;
      default:               w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic decoded_t decode_slot(input logic [31:0] word);
    decoded_t d;
    d.op  = op_t'(word[OP_MSB:OP_LSB]);
    d.rd  = word[RD_MSB:RD_LSB];
    d.rs1 = word[RS1_MSB:RS1_LSB];
    d.rs2 = word[RS2_MSB:RS2_LSB];
    d.imm = {{16{word[IMM_MSB]}}, word[IMM_MSB:IMM_LSB]};
    d.we  = writes_rd(d.op) && (d.rd != 5'd0);
    d.ld  = is_load(d.op);
    if (d.op == OP_NOP) begin
      d = NOP;
    end else begin
      d = d;
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Per-register load-latency counters: two set ports, four source read ports,
// every unset counter decays by one per cycle.
module scoreboard #(
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set0_en,
  input  logic [4:0]      set0_idx,
  input  logic            set1_en,
  input  logic [4:0]      set1_idx,
  input  logic [3:0][4:0] rd_idx,
  output logic [3:0]      rd_busy
);

  localparam logic [1:0] LAT_C = 2'(LOAD_LAT);

  logic [1:0] cnt_r [32];

  // Counter update: a set wins, otherwise decrement saturating at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt_r[i] <= 2'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if ((set0_en && (set0_idx == 5'(i))) || (set1_en && (set1_idx == 5'(i)))) begin
          cnt_r[i] <= LAT_C;
        end else if (cnt_r[i] != 2'd0) begin
          cnt_r[i] <= cnt_r[i] - 2'd1;
        end else begin
          cnt_r[i] <= 2'd0;
        end
      end
    end
  end

  // Source lookup; register 0 is never busy.
  always_comb begin
    rd_busy = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      rd_busy[k] = (rd_idx[k] != 5'd0) && (cnt_r[rd_idx[k]] != 2'd0);
    end
  end

endmodule

// File: rtl/decode_issue.sv
// Dual-slot decode and in-order issue with load-use interlock and
// intra-bundle dependency splitting.
module decode_issue
  import inst_package::*;
#(
  parameter int LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [63:0] inst_in,
  input  logic        branch_flag,
  output logic        interlock,
  output logic [31:0] pc_out,
  output decoded_t    dec0,
  output decoded_t    dec1
);

  decoded_t     d0_s, d1_s, dec0_s, dec1_s;
  decoded_t     dec0_r, dec1_r;
  logic [31:0]  pc_out_r;
  issue_state_t state_r, next_state_s;
  logic [3:0]   busy_s;
  logic         haz0_s, haz1_s, split_s, stall_s;

  assign d0_s = decode_slot(inst_in[63:32]);
  assign d1_s = decode_slot(inst_in[31:0]);

  assign haz0_s  = busy_s[0] | busy_s[1];
  assign haz1_s  = busy_s[2] | busy_s[3];
  assign split_s = d0_s.we && ((d1_s.rs1 == d0_s.rd) || (d1_s.rs2 == d0_s.rd) ||
                               (d1_s.we && (d1_s.rd == d0_s.rd)));

  scoreboard #(.LOAD_LAT(LOAD_LAT)) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set0_en  (dec0_s.ld & dec0_s.we),
    .set0_idx (dec0_s.rd),
    .set1_en  (dec1_s.ld & dec1_s.we),
    .set1_idx (dec1_s.rd),
    .rd_idx   ({d1_s.rs2, d1_s.rs1, d0_s.rs2, d0_s.rs1}),
    .rd_busy  (busy_s)
  );

  // Issue decision; a flush overrides everything and clears the split.
  always_comb begin
    next_state_s = state_r;
    dec0_s       = NOP;
    dec1_s       = NOP;
    stall_s      = 1'b0;
    if (branch_flag) begin
      next_state_s = S_FULL;
    end else begin
      case (state_r)
        S_FULL: begin
          if (haz0_s) begin
            stall_s = 1'b1;
          end else if (split_s || haz1_s) begin
            dec0_s       = d0_s;
            stall_s      = 1'b1;
            next_state_s = S_SECOND;
          end else begin
            dec0_s = d0_s;
            dec1_s = d1_s;
          end
        end
        S_SECOND: begin
          if (haz1_s) begin
            stall_s = 1'b1;
          end else begin
            dec1_s       = d1_s;
            next_state_s = S_FULL;
          end
        end
        default: next_state_s = S_FULL;
      endcase
    end
  end

  // Reset must drop the hold request immediately, not on the next edge.
  assign interlock = ~rst & stall_s;

  // Registered issue outputs and split state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_FULL;
      pc_out_r <= 32'd0;
      dec0_r   <= NOP;
      dec1_r   <= NOP;
    end else begin
      state_r  <= next_state_s;
      pc_out_r <= branch_flag ? 32'd0 : pc_in;
      dec0_r   <= dec0_s;
      dec1_r   <= dec1_s;
    end
  end

  assign pc_out = pc_out_r;
  assign dec0   = dec0_r;
  assign dec1   = dec1_r;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: issue, load-use stall, split, flush and
// reset-in-split scenarios with hand-computed decoded values.
module tb_decode_issue;
  import inst_package::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic [63:0] inst_in;
  logic        branch_flag;
  logic        interlock;
  logic [31:0] pc_out;
  decoded_t    dec0, dec1;

  int n_assert = 0;
  int n_fail   = 0;

  decode_issue #(.LOAD_LAT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .inst_in     (inst_in),
    .branch_flag (branch_flag),
    .interlock   (interlock),
    .pc_out      (pc_out),
    .dec0        (dec0),
    .dec1        (dec1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins(input op_t op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  function automatic decoded_t ex(input op_t op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [31:0] imm,
                                  input logic we, input logic ld);
    decoded_t d;
    d.op = op; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.imm = imm; d.we = we; d.ld = ld;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [63:0] inst, input logic br);
    pc_in = pc; inst_in = inst; branch_flag = br;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input decoded_t e0, input decoded_t e1,
                         input logic [31:0] epc);
    chk({tag, ".dec0"}, 64'(dec0), 64'(e0));
    chk({tag, ".dec1"}, 64'(dec1), 64'(e1));
    chk({tag, ".pc"}, 64'(pc_out), 64'(epc));
  endtask

  decoded_t e_nop, e_add3, e_add4, e_ld3, e_add4_3, e_add9, e_sub9;
  decoded_t e_add0, e_add1, e_ld7, e_add8, e_add11;

  initial begin
    e_nop    = ex(OP_NOP, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 1'b0);
    e_add3   = ex(OP_ADD, 5'd3, 5'd1, 5'd2, 32'h0000_1000, 1'b1, 1'b0);
    e_add4   = ex(OP_ADD, 5'd4, 5'd5, 5'd6, 32'h0000_3000, 1'b1, 1'b0);
    e_ld3    = ex(OP_LD, 5'd3, 5'd1, 5'd31, 32'hFFFF_FFF0, 1'b1, 1'b1);
    e_add4_3 = ex(OP_ADD, 5'd4, 5'd3, 5'd1, 32'h0000_0800, 1'b1, 1'b0);
    e_add9   = ex(OP_ADD, 5'd9, 5'd1, 5'd2, 32'h0000_1000, 1'b1, 1'b0);
    e_sub9   = ex(OP_SUB, 5'd9, 5'd5, 5'd6, 32'h0000_3000, 1'b1, 1'b0);
    e_add0   = ex(OP_ADD, 5'd0, 5'd1, 5'd2, 32'h0000_1000, 1'b0, 1'b0);
    e_add1   = ex(OP_ADD, 5'd1, 5'd0, 5'd0, 32'h0, 1'b1, 1'b0);
    e_ld7    = ex(OP_LD, 5'd7, 5'd0, 5'd0, 32'h0000_0004, 1'b1, 1'b1);
    e_add8   = ex(OP_ADD, 5'd8, 5'd7, 5'd0, 32'h0, 1'b1, 1'b0);
    e_add11  = ex(OP_ADD, 5'd11, 5'd7, 5'd0, 32'h0, 1'b1, 1'b0);

    // Reset with a split-worthy bundle presented: hold must stay low.
    rst = 1'b1;
    drive(32'h55, {ins(OP_ADD, 5'd9, 5'd1, 16'h1000), ins(OP_SUB, 5'd9, 5'd5, 16'h3000)}, 1'b0);
    chk("rst.il", 64'(interlock), 64'd0);
    chk_out("rst", e_nop, e_nop, 32'h0);
    step();
    chk_out("rst.held", e_nop, e_nop, 32'h0);
    rst = 1'b0;

    // Independent pair issues together.
    drive(32'h100, {ins(OP_ADD, 5'd3, 5'd1, 16'h1000), ins(OP_ADD, 5'd4, 5'd5, 16'h3000)}, 1'b0);
    chk("pair.il", 64'(interlock), 64'd0);
    step();
    chk_out("pair", e_add3, e_add4, 32'h100);

    // Load in slot0 feeding slot1: split, then LOAD_LAT stall cycles.
    drive(32'h108, {ins(OP_LD, 5'd3, 5'd1, 16'hFFF0), ins(OP_ADD, 5'd4, 5'd3, 16'h0800)}, 1'b0);
    chk("ldu.c0.il", 64'(interlock), 64'd1);
    step();
    chk_out("ldu.c1", e_ld3, e_nop, 32'h108);
    chk("ldu.c1.il", 64'(interlock), 64'd1);
    step();
    chk_out("ldu.c2", e_nop, e_nop, 32'h108);
    chk("ldu.c2.il", 64'(interlock), 64'd1);
    step();
    chk_out("ldu.c3", e_nop, e_nop, 32'h108);
    chk("ldu.c3.il", 64'(interlock), 64'd0);
    step();
    chk_out("ldu.c4", e_nop, e_add4_3, 32'h108);

    // WAW on r9 splits into two issue cycles.
    drive(32'h110, {ins(OP_ADD, 5'd9, 5'd1, 16'h1000), ins(OP_SUB, 5'd9, 5'd5, 16'h3000)}, 1'b0);
    chk("waw.c0.il", 64'(interlock), 64'd1);
    step();
    chk_out("waw.c1", e_add9, e_nop, 32'h110);
    chk("waw.c1.il", 64'(interlock), 64'd0);
    step();
    chk_out("waw.c2", e_nop, e_sub9, 32'h110);

    // r0 destination creates no dependency.
    drive(32'h118, {ins(OP_ADD, 5'd0, 5'd1, 16'h1000), ins(OP_ADD, 5'd1, 5'd0, 16'h0000)}, 1'b0);
    chk("r0.il", 64'(interlock), 64'd0);
    step();
    chk_out("r0", e_add0, e_add1, 32'h118);

    // ld r7 then a slot0 reader: exactly two Nop bundles.
    drive(32'h120, {ins(OP_LD, 5'd7, 5'd0, 16'h0004), 32'h0}, 1'b0);
    chk("ld7.il", 64'(interlock), 64'd0);
    step();
    chk_out("ld7", e_ld7, e_nop, 32'h120);
    drive(32'h128, {ins(OP_ADD, 5'd8, 5'd7, 16'h0000), 32'h0}, 1'b0);
    chk("use7.c1.il", 64'(interlock), 64'd1);
    step();
    chk_out("use7.c2", e_nop, e_nop, 32'h128);
    chk("use7.c2.il", 64'(interlock), 64'd1);
    step();
    chk_out("use7.c3", e_nop, e_nop, 32'h128);
    chk("use7.c3.il", 64'(interlock), 64'd0);
    step();
    chk_out("use7.c4", e_add8, e_nop, 32'h128);

    // Stall in S_SECOND, then flush; r7 keeps decaying across the flush.
    drive(32'h130, {ins(OP_LD, 5'd7, 5'd0, 16'h0004), ins(OP_ADD, 5'd10, 5'd7, 16'h0000)}, 1'b0);
    chk("fl.c0.il", 64'(interlock), 64'd1);
    step();
    chk_out("fl.c1", e_ld7, e_nop, 32'h130);
    chk("fl.c1.stall", 64'(interlock), 64'd1);
    drive(32'h130, {ins(OP_LD, 5'd7, 5'd0, 16'h0004), ins(OP_ADD, 5'd10, 5'd7, 16'h0000)}, 1'b1);
    chk("fl.c1.br.il", 64'(interlock), 64'd0);
    step();
    chk_out("fl.c2", e_nop, e_nop, 32'h0);
    drive(32'h200, {ins(OP_ADD, 5'd11, 5'd7, 16'h0000), 32'h0}, 1'b0);
    chk("fl.c2.decay.il", 64'(interlock), 64'd1);
    step();
    chk_out("fl.c3", e_nop, e_nop, 32'h200);
    chk("fl.c3.il", 64'(interlock), 64'd0);
    step();
    chk_out("fl.c4", e_add11, e_nop, 32'h200);

    // Reset while waiting to issue slot1 abandons it.
    drive(32'h208, {ins(OP_ADD, 5'd9, 5'd1, 16'h1000), ins(OP_SUB, 5'd9, 5'd5, 16'h3000)}, 1'b0);
    chk("rs.c0.il", 64'(interlock), 64'd1);
    step();
    chk_out("rs.c1", e_add9, e_nop, 32'h208);
    rst = 1'b1;
    #1;
    chk_out("rs.async", e_nop, e_nop, 32'h0);
    chk("rs.async.il", 64'(interlock), 64'd0);
    step();
    rst = 1'b0;
    drive(32'h300, {ins(OP_ADD, 5'd3, 5'd1, 16'h1000), ins(OP_ADD, 5'd4, 5'd5, 16'h3000)}, 1'b0);
    chk("rs.post.il", 64'(interlock), 64'd0);
    step();
    chk_out("rs.post", e_add3, e_add4, 32'h300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
